// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial transmit path
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [2:0] SIZE_5 = 3'd0;
    localparam logic [2:0] SIZE_6 = 3'd1;
    localparam logic [2:0] SIZE_7 = 3'd2;
    localparam logic [2:0] SIZE_8 = 3'd3;
    localparam logic [2:0] SIZE_9 = 3'd4;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int CTRL_EN       = 7;
    localparam int CTRL_STOP2    = 6;
    localparam int CTRL_PAR_LSB  = 4;
    localparam int CTRL_SIZE_LSB = 0;

    // Reserved size codes fall back to 8 data bits.
    function automatic logic [3:0] size_bits(input logic [2:0] code);
        case (code)
            SIZE_5:  size_bits = 4'd5;
            SIZE_6:  size_bits = 4'd6;
            SIZE_7:  size_bits = 4'd7;
            SIZE_9:  size_bits = 4'd9;
            default: size_bits = 4'd8;
        endcase
    endfunction

    function automatic logic [8:0] size_mask(input logic [2:0] code);
        case (code)
            SIZE_5:  size_mask = 9'h01F;
            SIZE_6:  size_mask = 9'h03F;
            SIZE_7:  size_mask = 9'h07F;
            SIZE_9:  size_mask = 9'h1FF;
            default: size_mask = 9'h0FF;
        endcase
    endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// rtl/serial_baud_gen.sv - fractional baud tick generator with divisor clamping
module serial_baud_gen #(
    parameter logic [31:0] BRD_MIN = 32'h0000_0200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [31:0] i_brd,
    output logic        o_tick
);

    logic [31:0] r_cnt;
    logic [31:0] w_brd_eff;
    logic [32:0] w_sum;

    assign w_brd_eff = (i_brd < BRD_MIN) ? BRD_MIN : i_brd;
    // Carry bit kept so the compare is exact even near 2^32.
    assign w_sum     = {1'b0, r_cnt} + 33'd256;
    assign o_tick    = i_enable && (w_sum >= {1'b0, w_brd_eff});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 32'd0;
        end else if (i_clear) begin
            r_cnt <= 32'd0;
        end else if (i_enable) begin
            if (o_tick) begin
                r_cnt <= 32'(w_sum - {1'b0, w_brd_eff});
            end else begin
                r_cnt <= w_sum[31:0];
            end
        end
    end

endmodule

// File: rtl/serial_tx_ctrl.sv
// rtl/serial_tx_ctrl.sv - FIFO-draining serial transmit sequencer
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter logic [31:0] BRD_MIN = 32'h0000_0200
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [31:0] control,
    input  logic [31:0] brd,
    input  logic        fifo_empty,
    input  logic [8:0]  fifo_rd_data,
    output logic        fifo_rd_request,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;

    logic        r_tx;
    logic        r_busy;
    logic        r_tx_done;
    logic        r_rd_req;
    logic        w_tx_nxt;
    logic        w_done_nxt;
    logic        w_rd_nxt;

    logic [8:0]  r_shift;
    logic [3:0]  r_bit_idx;
    logic        r_stop_idx;
    logic        r_par_bit;
    logic [6:0]  r_ctrl_sh;
    logic [31:0] r_brd_sh;

    logic        w_tick;
    logic        w_baud_en;
    logic        w_baud_clr;
    logic        w_par_en;
    logic [3:0]  w_last_idx;
    logic [8:0]  w_load_data;
    logic        w_load_par;
    logic        w_unused;

    assign w_unused = &{1'b0, control[31:8], control[3]};

    // Unsent upper bits are masked off so parity covers only transmitted bits.
    assign w_load_data = fifo_rd_data & size_mask(control[CTRL_SIZE_LSB +: 3]);
    assign w_load_par  = (^w_load_data) ^ (control[CTRL_PAR_LSB +: 2] == PAR_ODD);

    assign w_par_en   = (r_ctrl_sh[CTRL_PAR_LSB +: 2] == PAR_EVEN) ||
                        (r_ctrl_sh[CTRL_PAR_LSB +: 2] == PAR_ODD);
    assign w_last_idx = size_bits(r_ctrl_sh[CTRL_SIZE_LSB +: 3]) - 4'd1;

    assign w_baud_clr = (r_state == LOAD);
    assign w_baud_en  = (r_state == START) || (r_state == DATA) ||
                        (r_state == PARITY) || (r_state == STOP);

    serial_baud_gen #(
        .BRD_MIN (BRD_MIN)
    ) u_baud (
        .i_clk    (S_AXI_ACLK),
        .i_rst_n  (S_AXI_ARESETN),
        .i_clear  (w_baud_clr),
        .i_enable (w_baud_en),
        .i_brd    (r_brd_sh),
        .o_tick   (w_tick)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are computed for the next state and registered alongside it.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        w_rd_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (control[CTRL_EN] && !fifo_empty) begin
                    w_state_nxt = POP;
                    w_rd_nxt    = 1'b1;
                end
            end
            POP: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_state_nxt = START;
                w_tx_nxt    = 1'b0;
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == w_last_idx) begin
                        if (w_par_en) begin
                            w_state_nxt = PARITY;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_tick && !(r_ctrl_sh[CTRL_STOP2] && !r_stop_idx)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rd_req   <= 1'b0;
            r_shift    <= 9'd0;
            r_bit_idx  <= 4'd0;
            r_stop_idx <= 1'b0;
            r_par_bit  <= 1'b0;
            r_ctrl_sh  <= 7'd0;
            r_brd_sh   <= 32'd0;
        end else begin
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_tx_done <= w_done_nxt;
            r_rd_req  <= w_rd_nxt;
            case (r_state)
                LOAD: begin
                    r_shift    <= w_load_data;
                    r_par_bit  <= w_load_par;
                    r_ctrl_sh  <= control[6:0];
                    r_brd_sh   <= brd;
                    r_bit_idx  <= 4'd0;
                    r_stop_idx <= 1'b0;
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= {1'b0, r_shift[8:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tx              = r_tx;
    assign busy            = r_busy;
    assign tx_done         = r_tx_done;
    assign fifo_rd_request = r_rd_req;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb/tb_serial_tx_ctrl.sv - scoreboard bench for serial_tx_ctrl
module tb_serial_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] control = 32'd0;
    logic [31:0] brd = 32'd0;
    logic        fifo_empty;
    logic [8:0]  fifo_rd_data = 9'd0;
    logic        fifo_rd_request;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_tx_ctrl dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESETN   (rst_n),
        .control         (control),
        .brd             (brd),
        .fifo_empty      (fifo_empty),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_rd_request (fifo_rd_request),
        .tx              (tx),
        .busy            (busy),
        .tx_done         (tx_done)
    );

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: data appears the cycle after the pop request
    logic [8:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_count = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_request) begin
            check(!fifo_empty, "rd_while_empty", 1, 0);
            fifo_rd_data <= mem[rd_ptr[3:0]];
            rd_ptr       <= rd_ptr + 1;
            rd_count     <= rd_count + 1;
        end
    end

    task automatic push(input logic [8:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    int busy_cnt = 0;
    always @(negedge clk) if (busy) busy_cnt++;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          per_a;
        int          per_b;
        int          gap;
    } exp_t;

    exp_t sb[$];

    task automatic expect_frame(input logic [15:0] bits, input int nbits, input int pa,
                                input int pb, input int gap);
        exp_t e;
        e.bits = bits; e.nbits = nbits; e.per_a = pa; e.per_b = pb; e.gap = gap;
        sb.push_back(e);
    endtask

    // Monitor: captures tx per clock from start-bit fall until tx_done
    bit   in_frame = 1'b0;
    bit   done_prev = 1'b0;
    int   len = 0;
    int   idle_cnt = 0;
    int   start_gap = 0;
    logic samples [0:511];

    task automatic finish_frame();
        exp_t e;
        int   idx;
        int   total;
        int   first_bad;
        int   p;
        if (sb.size() == 0) begin
            check(1'b0, "unexpected_frame", len, 0);
            return;
        end
        e = sb.pop_front();
        idx = 0;
        total = 0;
        first_bad = -1;
        for (int j = 0; j < e.nbits; j++) begin
            p = (j % 2 == 0) ? e.per_a : e.per_b;
            total += p;
            for (int c = 0; c < p; c++) begin
                if (idx < len && first_bad < 0 && samples[idx] !== e.bits[j]) first_bad = idx;
                idx++;
            end
        end
        check(len == total, "frame_len", len, total);
        check(first_bad < 0, "frame_bits_first_bad_clock", first_bad, -1);
        if (e.gap >= 0) check(start_gap == e.gap, "idle_gap", start_gap, e.gap);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            done_prev = 1'b0;
            idle_cnt  = 0;
        end else begin
            if (done_prev) check(tx_done == 1'b0, "done_width", tx_done, 0);
            done_prev = tx_done;
            if (tx_done) begin
                if (in_frame) finish_frame();
                else check(1'b0, "done_without_frame", 1, 0);
                in_frame = 1'b0;
                idle_cnt = 1;
            end else if (in_frame) begin
                samples[len] = tx;
                len++;
            end else if (tx == 1'b0) begin
                in_frame   = 1'b1;
                start_gap  = idle_cnt;
                samples[0] = tx;
                len        = 1;
            end else begin
                idle_cnt++;
            end
        end
    end

    task automatic wait_sb(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(sb.size() == 0, "scoreboard_timeout", sb.size(), 0);
    endtask

    task automatic wait_tx_low(input int max_cycles);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tx === 1'b0, "tx_fall_timeout", tx, 0);
    endtask

    int r0;
    int b0;
    int low_cnt;

    initial begin
        repeat (3) @(negedge clk);
        check(tx == 1'b1, "reset_tx", tx, 1);
        check(busy == 1'b0, "reset_busy", busy, 0);
        check(tx_done == 1'b0, "reset_done", tx_done, 0);
        check(fifo_rd_request == 1'b0, "reset_rd_req", fifo_rd_request, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1, 10 clocks per bit
        brd = 32'h0A00; control = 32'h83;
        r0 = rd_count; b0 = busy_cnt;
        expect_frame(16'h02AA, 10, 10, 10, -1);
        push(9'h055);
        wait_sb(400);
        check(rd_count - r0 == 1, "t1_pops", rd_count - r0, 1);
        check(busy_cnt - b0 == 102, "t1_busy_clocks", busy_cnt - b0, 102);

        // Fractional divisor 10.5
        brd = 32'h0A80;
        expect_frame(16'h03FE, 10, 11, 10, -1);
        push(9'h0FF);
        wait_sb(400);

        // 7E2 then 7O2
        brd = 32'h0400; control = 32'hD2;
        expect_frame(16'h0606, 11, 4, 4, -1);
        push(9'h003);
        wait_sb(200);
        control = 32'hE2;
        expect_frame(16'h0706, 11, 4, 4, -1);
        push(9'h003);
        wait_sb(200);

        // 9-bit, back-to-back words
        control = 32'h84;
        expect_frame(16'h0754, 11, 4, 4, -1);
        expect_frame(16'h05E0, 11, 4, 4, 3);
        push(9'h1AA);
        push(9'h0F0);
        wait_sb(300);

        // Enable dropped mid-frame with words still queued
        control = 32'h83;
        r0 = rd_count;
        expect_frame(16'h034A, 10, 4, 4, -1);
        push(9'h0A5); push(9'h011); push(9'h022);
        wait_tx_low(50);
        repeat (10) @(negedge clk);
        control = 32'h03;
        wait_sb(200);
        low_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx == 1'b0) low_cnt++;
        end
        check(low_cnt == 0, "t6_tx_idle_low_clocks", low_cnt, 0);
        check(rd_count - r0 == 1, "t6_pops", rd_count - r0, 1);
        wr_ptr = rd_ptr;

        // Async reset mid-DATA, then clamped divisor
        control = 32'h83; brd = 32'h0400;
        push(9'h0FF);
        wait_tx_low(50);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(tx == 1'b1, "rst_async_tx", tx, 1);
        check(busy == 1'b0, "rst_async_busy", busy, 0);
        check(fifo_rd_request == 1'b0, "rst_async_rd_req", fifo_rd_request, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r0 = rd_count;
        repeat (20) @(negedge clk);
        check(rd_count == r0, "rst_empty_no_pop", rd_count - r0, 0);
        check(tx == 1'b1, "rst_tx_idle", tx, 1);
        brd = 32'd0;
        expect_frame(16'h02AA, 10, 2, 2, -1);
        push(9'h055);
        wait_sb(200);
        check(rd_count - r0 == 1, "t7_pops", rd_count - r0, 1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
